// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and off-chip memory.
// Hits complete combinationally in IDLE; misses stall while a dirty victim is written back and the line is refilled.
module dcache_controller #(
  parameter int NUM_SETS = 16,
  parameter int INDEX_W  = 4,
  parameter int LINE_W   = 256,
  parameter int TAG_W    = 32 - INDEX_W - 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int WORDS = LINE_W / 32;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state_reg, state_next;

  logic [NUM_SETS-1:0] valid_reg;
  logic [NUM_SETS-1:0] dirty_reg;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   line_mem [NUM_SETS];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [2:0]         req_word;
  logic [TAG_W-1:0]   cur_tag;
  logic [LINE_W-1:0]  cur_line;
  logic [LINE_W-1:0]  merged_line;
  logic [31:0]        line_words [WORDS];
  logic               request;
  logic               hit;
  logic               unused_ok;

  assign req_tag   = addr_i[31:32-TAG_W];
  assign req_index = addr_i[5 +: INDEX_W];
  assign req_word  = addr_i[4:2];
  assign unused_ok = &{1'b0, addr_i[1:0]};

  assign cur_tag  = tag_mem[req_index];
  assign cur_line = line_mem[req_index];

  assign request = MemRead_i | MemWrite_i;
  assign hit     = (state_reg == IDLE) & valid_reg[req_index] & (cur_tag == req_tag);
  assign stall_o = request & ~hit;

  // Word view of the selected line and the same line with the store word merged in
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_words
      assign line_words[gi] = cur_line[gi*32 +: 32];
      assign merged_line[gi*32 +: 32] = (req_word == 3'(gi)) ? data_i : cur_line[gi*32 +: 32];
    end
  endgenerate

  assign data_o = (hit & MemRead_i & ~MemWrite_i) ? line_words[req_word] : 32'h0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ALLOCATE && mem_ack_i) begin
        valid_reg[req_index] <= 1'b1;
        dirty_reg[req_index] <= 1'b0;
      end else if (hit && MemWrite_i) begin
        dirty_reg[req_index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard their contents
  always_ff @(posedge clk_i) begin
    if (state_reg == ALLOCATE && mem_ack_i) begin
      line_mem[req_index] <= mem_data_i;
      tag_mem[req_index]  <= req_tag;
    end else if (hit && MemWrite_i) begin
      line_mem[req_index] <= merged_line;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = '0;
    unique case (state_reg)
      IDLE: begin
        if (request && !hit) begin
          if (valid_reg[req_index] && dirty_reg[req_index]) state_next = WRITEBACK;
          else                                                state_next = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {cur_tag, req_index, 5'b0};
        mem_data_o   = cur_line;
        if (mem_ack_i) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, req_index, 5'b0};
        if (mem_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
